// File: rtl/icache_axi_refill_master_if.sv
// AXI4 read-address / read-data channel bundle between the I-cache refill
// master and the instruction-memory read slave.
interface icache_axi_refill_master_if #(
  parameter int ADDR_W = 32
);
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              rvalid;
  logic              rready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rlast;

  modport master (
    output arvalid, araddr, arlen, arsize, arburst, rready,
    input  arready, rvalid, rdata, rresp, rlast
  );

  modport slave (
    input  arvalid, araddr, arlen, arsize, arburst, rready,
    output arready, rvalid, rdata, rresp, rlast
  );
endinterface

// File: rtl/icache_axi_refill_master.sv
// I-cache line refill master: takes one refill request, issues a single AXI4
// INCR burst of LINE_WORDS 32-bit beats, assembles the line and hands it back
// as a one-cycle response pulse.
// Optional build macro AXI_REFILL_ERR_CHECK_EN adds refill error tracking
// (bad rresp, early rlast, late/missing rlast); without it resp_err is 0.

// One 32-bit slot of the line buffer; written when its beat arrives.
module icache_refill_word (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] word_q
);
  logic [31:0] word_d;

  // Capture the beat for this slot, otherwise hold the previous contents.
  always_comb begin
    word_d = word_q;
    if (we) word_d = wdata;
  end

  // Slot storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) word_q <= '0;
    else        word_q <= word_d;
  end
endmodule

module icache_axi_refill_master #(
  parameter int ADDR_W     = 32,
  parameter int LINE_WORDS = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_W-1:0]        req_addr,
  output logic                     resp_valid,
  output logic [LINE_WORDS*32-1:0] resp_data,
  output logic                     resp_err,
  icache_axi_refill_master_if.master axi
);
  localparam int OFF_W = $clog2(LINE_WORDS * 4);
  localparam int CNT_W = $clog2(LINE_WORDS) + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(LINE_WORDS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_RESP} state_e;

  state_e                         state_q, state_d;
  logic [ADDR_W-1:0]              addr_q, addr_d;
  logic [CNT_W-1:0]               beat_cnt_q, beat_cnt_d;
  logic                           beat_hs;
  logic                           beat_store;
  logic                           req_hs;
  logic [LINE_WORDS-1:0][31:0]    line_q;

  // Byte offset within the line is dropped when the address is latched.
  logic unused_addr_lo;
  assign unused_addr_lo = ^req_addr[OFF_W-1:0];

  assign req_hs  = (state_q == S_IDLE) && req_valid;
  assign beat_hs = (state_q == S_R) && axi.rvalid;

  // Next-state, address latch and beat counter.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    beat_cnt_d = beat_cnt_q;
    beat_store = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d     = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          beat_cnt_d = '0;
          state_d    = S_AR;
        end
      end
      S_AR: begin
        if (axi.arready) state_d = S_R;
      end
      S_R: begin
        if (beat_hs) begin
          // Beats past the end of the line are accepted but dropped.
          if (beat_cnt_q < CNT_FULL) begin
            beat_store = 1'b1;
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
          // Only rlast closes the burst, never the beat count on its own.
          if (axi.rlast) state_d = S_RESP;
        end
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Line buffer: one slot per word, selected by the running beat count.
  for (genvar i = 0; i < LINE_WORDS; i++) begin : g_word
    icache_refill_word u_word (
      .clk    (clk),
      .rst_n  (rst_n),
      .we     (beat_store && (beat_cnt_q == CNT_W'(i))),
      .wdata  (axi.rdata),
      .word_q (line_q[i])
    );
  end

`ifdef AXI_REFILL_ERR_CHECK_EN
  logic err_q, err_d;

  // Sticky per-refill error: bad response, early rlast, or beats beyond the line.
  always_comb begin
    err_d = err_q;
    if (req_hs) err_d = 1'b0;
    if (beat_hs) begin
      if (axi.rresp != 2'b00)                  err_d = 1'b1;
      if (axi.rlast && beat_cnt_q != CNT_LAST) err_d = 1'b1;
      if (beat_cnt_q == CNT_FULL)              err_d = 1'b1;
    end
  end

  // Error flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign resp_err = err_q && (state_q == S_RESP);
`else
  logic unused_rresp;
  logic unused_req_hs;
  assign unused_rresp  = ^axi.rresp;
  assign unused_req_hs = req_hs;
  assign resp_err      = 1'b0;
`endif

  assign req_ready   = (state_q == S_IDLE);
  assign resp_valid  = (state_q == S_RESP);
  assign resp_data   = line_q;

  assign axi.arvalid = (state_q == S_AR);
  assign axi.araddr  = addr_q;
  assign axi.arlen   = 8'(LINE_WORDS - 1);
  assign axi.arsize  = 3'b010;
  assign axi.arburst = 2'b01;
  assign axi.rready  = (state_q == S_R);
endmodule

// File: tb/tb_icache_axi_refill_master.sv
// Directed bench for icache_axi_refill_master: the AXI slave side is driven
// step by step from one initial block; outputs are sampled on the falling edge.
module tb_icache_axi_refill_master;
  localparam int LW = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid;
  logic         req_ready;
  logic [31:0]  req_addr;
  logic         resp_valid;
  logic [255:0] resp_data;
  logic         resp_err;

  icache_axi_refill_master_if #(.ADDR_W(32)) axi_if ();

  icache_axi_refill_master #(.ADDR_W(32), .LINE_WORDS(LW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .axi        (axi_if)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int pulses, rdy_cnt, arv_cnt, rr_cnt, ar_bad, cyc_n, resp_cyc;
  logic [31:0]          exp_ar, cap_ar;
  logic [255:0]         cap_data;
  logic                 cap_err;
  logic [LW-1:0][31:0]  exp_line;
  logic                 exp_err_en;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sample outputs mid-cycle, then advance to just after the next rising edge.
  task automatic cycle();
    @(negedge clk);
    if (resp_valid === 1'b1) begin
      pulses++; cap_data = resp_data; cap_err = resp_err; resp_cyc = cyc_n;
    end
    if (req_ready === 1'b1) rdy_cnt++;
    if (axi_if.arvalid === 1'b1) begin
      arv_cnt++; cap_ar = axi_if.araddr;
      if (axi_if.araddr !== exp_ar) ar_bad++;
    end
    if (axi_if.rready === 1'b1) rr_cnt++;
    cyc_n++;
    @(posedge clk); #1;
  endtask

  task automatic refill(input logic [31:0] addr, input logic [31:0] line_addr,
                        input int ar_stall, input int gap, input int nbeats,
                        input int bad_beat, input logic [31:0] seed,
                        input bit skip_accept, input bit hold,
                        input logic [31:0] next_addr, input int tail);
    pulses = 0; arv_cnt = 0; rr_cnt = 0; ar_bad = 0; rdy_cnt = 0;
    cyc_n = skip_accept ? 1 : 0; resp_cyc = -1;
    cap_err = 1'bx; cap_data = '0; cap_ar = '0; exp_ar = line_addr;
    if (!skip_accept) begin
      req_valid = 1'b1; req_addr = addr;
      cycle();
    end
    if (hold) begin req_valid = 1'b1; req_addr = next_addr; end
    else req_valid = 1'b0;
    rdy_cnt = 0;
    axi_if.arready = 1'b0;
    for (int c = 0; c < ar_stall; c++) cycle();
    axi_if.arready = 1'b1;
    cycle();
    axi_if.arready = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      if (gap > 0 && (b % 2) == 1) begin
        axi_if.rvalid = 1'b0;
        cycle();
      end
      axi_if.rvalid = 1'b1;
      axi_if.rdata  = seed + 32'h11 * (b + 1);
      axi_if.rresp  = (b == bad_beat) ? 2'b10 : 2'b00;
      axi_if.rlast  = (b == nbeats - 1);
      if (b < LW) exp_line[b] = axi_if.rdata;
      cycle();
    end
    axi_if.rvalid = 1'b0; axi_if.rlast = 1'b0; axi_if.rresp = 2'b00; axi_if.rdata = '0;
    for (int k = 0; k < tail; k++) cycle();
  endtask

  initial begin
`ifdef AXI_REFILL_ERR_CHECK_EN
    exp_err_en = 1'b1;
`else
    exp_err_en = 1'b0;
`endif
    req_valid = 1'b0; req_addr = '0;
    axi_if.arready = 1'b0; axi_if.rvalid = 1'b0; axi_if.rdata = '0;
    axi_if.rresp = 2'b00; axi_if.rlast = 1'b0;
    exp_line = '0; exp_ar = '0;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_arvalid", axi_if.arvalid, 0);
    chk("rst_araddr", axi_if.araddr, 0);
    chk("rst_rready", axi_if.rready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_resp_err", resp_err, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic refill, minimum latency
    refill(32'h24, 32'h20, 0, 0, 8, -1, 32'h0, 0, 0, 0, 6);
    chk("basic_araddr", cap_ar, 32'h20);
    chk("basic_ar_bad", ar_bad, 0);
    chk("basic_arlen", axi_if.arlen, 7);
    chk("basic_arsize", axi_if.arsize, 2);
    chk("basic_arburst", axi_if.arburst, 1);
    chk("basic_pulses", pulses, 1);
    chk("basic_resp_cycle", resp_cyc, 10);
    chk("basic_word0", cap_data[31:0], 32'h11);
    chk("basic_word7", cap_data[255:224], 32'h88);
    chk("basic_line", cap_data, exp_line);
    chk("basic_err", cap_err, 0);
    chk("basic_arv_cycles", arv_cnt, 1);
    chk("basic_rready_cycles", rr_cnt, 8);
    chk("basic_ready_after", rdy_cnt, 5);

    // Backpressure on AR and R
    refill(32'h1000_0104, 32'h1000_0100, 5, 1, 8, -1, 32'hA000_0000, 0, 0, 0, 6);
    chk("bp_ar_stable", ar_bad, 0);
    chk("bp_araddr", cap_ar, 32'h1000_0100);
    chk("bp_arv_cycles", arv_cnt, 6);
    chk("bp_rready_cycles", rr_cnt, 12);
    chk("bp_pulses", pulses, 1);
    chk("bp_ready_busy", rdy_cnt, 5);
    chk("bp_line", cap_data, exp_line);
    chk("bp_err", cap_err, 0);

    // Short burst: rlast on the 6th beat, words 6..7 keep previous line
    refill(32'h40, 32'h40, 0, 0, 6, -1, 32'hB000_0000, 0, 0, 0, 6);
    chk("short_pulses", pulses, 1);
    chk("short_rready_cycles", rr_cnt, 6);
    chk("short_word6_kept", cap_data[223:192], 32'hA000_0077);
    chk("short_line", cap_data, exp_line);
    chk("short_err", cap_err, exp_err_en);

    // Error response on beat 4
    refill(32'h60, 32'h60, 0, 0, 8, 3, 32'hC000_0000, 0, 0, 0, 6);
    chk("rresp_pulses", pulses, 1);
    chk("rresp_line", cap_data, exp_line);
    chk("rresp_err", cap_err, exp_err_en);

    // Late rlast: 9 beats, the 9th is dropped
    refill(32'h80, 32'h80, 0, 0, 9, -1, 32'hD000_0000, 0, 0, 0, 6);
    chk("late_pulses", pulses, 1);
    chk("late_rready_cycles", rr_cnt, 9);
    chk("late_word7", cap_data[255:224], 32'hD000_0088);
    chk("late_line", cap_data, exp_line);
    chk("late_err", cap_err, exp_err_en);

    // Back-to-back: second request held high during the first refill
    refill(32'h200, 32'h200, 1, 0, 8, -1, 32'hE000_0000, 0, 1, 32'h31C, 2);
    chk("b2b1_pulses", pulses, 1);
    chk("b2b1_ready_busy", rdy_cnt, 1);
    chk("b2b1_line", cap_data, exp_line);
    chk("b2b1_err_clean", cap_err, 0);
    refill(32'h0, 32'h300, 0, 0, 8, -1, 32'hF000_0000, 1, 0, 0, 6);
    chk("b2b2_araddr", cap_ar, 32'h300);
    chk("b2b2_ar_bad", ar_bad, 0);
    chk("b2b2_pulses", pulses, 1);
    chk("b2b2_line", cap_data, exp_line);

    // Reset in the middle of a burst
    req_valid = 1'b1; req_addr = 32'h480;
    cycle();
    req_valid = 1'b0; axi_if.arready = 1'b1;
    cycle();
    axi_if.arready = 1'b0;
    for (int b = 0; b < 3; b++) begin
      axi_if.rvalid = 1'b1; axi_if.rdata = 32'h5A5A_0000 + b;
      cycle();
    end
    axi_if.rvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mrst_arvalid", axi_if.arvalid, 0);
    chk("mrst_rready", axi_if.rready, 0);
    chk("mrst_resp_valid", resp_valid, 0);
    chk("mrst_req_ready", req_ready, 1);
    chk("mrst_resp_data", resp_data, 0);
    exp_line = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    refill(32'h4A4, 32'h4A0, 2, 1, 8, -1, 32'h1234_0000, 0, 0, 0, 6);
    chk("post_rst_ar", ar_bad, 0);
    chk("post_rst_pulses", pulses, 1);
    chk("post_rst_line", cap_data, exp_line);
    chk("post_rst_err", cap_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
